// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants and the fetch-stage state encoding.
package core_pkg;

    localparam logic [5:0] OP_JUMP  = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JUMPR = 6'b001000;
    localparam logic [5:0] OP_IN    = 6'b011000;
    localparam logic [5:0] OP_HALT  = 6'b011011;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT_IN = 2'd1,
        S_HALTED  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: sequential step, conditional branch, jump target or register jump.
module next_pc_sel #(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       imm,
    input  logic [ADDR_W-1:0] jtarget,
    input  logic [ADDR_W-1:0] rs_target,
    input  logic              PcSrc,
    input  logic              J_Jr,
    input  logic              Branch,
    input  logic              Beq_Bne,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] offset;
    logic              taken;

    assign pc_plus1 = pc + ADDR_W'(1);
    // Sign-extend then truncate; all PC arithmetic wraps modulo 2^ADDR_W.
    assign offset   = ADDR_W'($signed(imm));
    assign taken    = Beq_Bne ? alu_zero : ~alu_zero;

    always_comb begin
        next_pc = pc_plus1;
        if (PcSrc) begin
            if (Branch && taken) next_pc = pc_plus1 + offset;
        end else if (J_Jr) begin
            next_pc = jtarget;
        end else begin
            next_pc = rs_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage: PC register, input-stall / halt FSM and next-PC mux.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  S_RUN     | normal fetch; pc advances to next_pc each cycle
//  S_WAIT_IN | "in" instruction waiting for in_valid; pc held, writes gated
//  S_HALTED  | halt executed; pc frozen until reset
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    input  logic               PcSrc,
    input  logic               J_Jr,
    input  logic               Branch,
    input  logic               Beq_Bne,
    input  logic               Halt,
    input  logic               alu_zero,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ack,
    output logic [DATA_W-1:0]  in_value,
    output logic               wr_allow,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] in_value_q;
    logic [ADDR_W-1:0] next_pc;
    logic              is_in_op;
    logic              is_halt_op;
    logic              unused_rs_hi;

    assign instr      = imem_data;
    assign opcode     = imem_data[INSTR_W-1 -: 6];
    assign is_in_op   = Halt && (opcode == OP_IN);
    // Any Halt assertion that is not an input request stops the core.
    assign is_halt_op = Halt && !is_in_op;
    assign unused_rs_hi = ^rs_data[DATA_W-1:ADDR_W];

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .pc        (pc_q),
        .imm       (imem_data[15:0]),
        .jtarget   (imem_data[ADDR_W-1:0]),
        .rs_target (rs_data[ADDR_W-1:0]),
        .PcSrc     (PcSrc),
        .J_Jr      (J_Jr),
        .Branch    (Branch),
        .Beq_Bne   (Beq_Bne),
        .alu_zero  (alu_zero),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            in_value_q <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (is_halt_op) begin
                        state_q <= S_HALTED;
                    end else if (is_in_op) begin
                        if (in_valid) begin
                            in_value_q <= in_data;
                            pc_q       <= next_pc;
                        end else begin
                            state_q <= S_WAIT_IN;
                        end
                    end else begin
                        pc_q <= next_pc;
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        in_value_q <= in_data;
                        pc_q       <= pc_q + ADDR_W'(1);
                        state_q    <= S_RUN;
                    end
                end
                S_HALTED: ;
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign in_ack   = rst_n && in_valid &&
                      (((state_q == S_RUN) && is_in_op) || (state_q == S_WAIT_IN));
    assign wr_allow = rst_n &&
                      (((state_q == S_RUN) && !(is_in_op && !in_valid)) ||
                       ((state_q == S_WAIT_IN) && in_valid));
    assign halted    = (state_q == S_HALTED);
    assign in_value  = in_value_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; the bench plays the decoder and memory.
module tb_pc_fetch_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        PcSrc, J_Jr, Branch, Beq_Bne, Halt, alu_zero;
    logic [31:0] rs_data;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ack;
    logic [31:0] in_value;
    logic        wr_allow;
    logic        halted;
    logic [9:0]  pc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .opcode(opcode), .PcSrc(PcSrc), .J_Jr(J_Jr), .Branch(Branch),
        .Beq_Bne(Beq_Bne), .Halt(Halt), .alu_zero(alu_zero), .rs_data(rs_data),
        .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack), .in_value(in_value),
        .wr_allow(wr_allow), .halted(halted), .pc(pc)
    );

    task automatic nop();
        imem_data = 32'h0;
        PcSrc = 1'b1; J_Jr = 1'b0; Branch = 1'b0; Beq_Bne = 1'b0; Halt = 1'b0;
        alu_zero = 1'b0; rs_data = 32'h0; in_valid = 1'b0; in_data = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [9:0] addr);
        imem_data = {OP_JUMP, 16'h0, addr};
        PcSrc = 1'b0; J_Jr = 1'b1;
        tick();
        nop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        nop();
        #12;
        tests++; if (pc !== 10'd0) begin fails++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
        tests++; if (in_ack !== 1'b0) begin fails++; $display("FAIL reset_in_ack: got %b expected 0", in_ack); end
        tests++; if (in_value !== 32'h0) begin fails++; $display("FAIL reset_in_value: got %0h expected 0", in_value); end
        tests++; if (wr_allow !== 1'b0) begin fails++; $display("FAIL reset_wr_allow: got %b expected 0", wr_allow); end
        rst_n = 1'b1;
        #1;
        tests++; if (wr_allow !== 1'b1) begin fails++; $display("FAIL release_wr_allow: got %b expected 1", wr_allow); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (imem_addr !== 10'(i)) begin
                fails++; $display("FAIL nop_fetch_%0d: got %0h expected %0h", i, imem_addr, i);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        goto(10'd5);
        tests++; if (pc !== 10'd5) begin fails++; $display("FAIL goto5: got %0h expected 5", pc); end
        imem_data = {OP_BEQ, 10'h0, 16'hFFFD};
        Branch = 1'b1; Beq_Bne = 1'b1; alu_zero = 1'b1;
        tick(); nop();
        tests++; if (pc !== 10'd3) begin fails++; $display("FAIL beq_taken: got %0h expected 3", pc); end
        goto(10'd5);
        imem_data = {OP_BNE, 10'h0, 16'hFFFD};
        Branch = 1'b1; Beq_Bne = 1'b0; alu_zero = 1'b1;
        tick(); nop();
        tests++; if (pc !== 10'd6) begin fails++; $display("FAIL bne_not_taken: got %0h expected 6", pc); end
        imem_data = {OP_BNE, 10'h0, 16'h0004};
        Branch = 1'b1; Beq_Bne = 1'b0; alu_zero = 1'b0;
        tick(); nop();
        tests++; if (pc !== 10'd11) begin fails++; $display("FAIL bne_taken: got %0h expected b", pc); end
        goto(10'd1);
        imem_data = {OP_BEQ, 10'h0, 16'hFFFB};
        Branch = 1'b1; Beq_Bne = 1'b1; alu_zero = 1'b1;
        tick(); nop();
        tests++; if (pc !== 10'd1021) begin fails++; $display("FAIL beq_wrap: got %0h expected 3fd", pc); end
    endtask

    task automatic test_jump();
        goto(10'h1F0);
        tests++; if (pc !== 10'h1F0) begin fails++; $display("FAIL jump: got %0h expected 1f0", pc); end
        imem_data = {OP_JUMPR, 26'h0};
        PcSrc = 1'b0; J_Jr = 1'b0; rs_data = 32'h0001_2345;
        tick(); nop();
        tests++; if (pc !== 10'h345) begin fails++; $display("FAIL jumpr: got %0h expected 345", pc); end
        imem_data = {OP_JAL, 16'h0, 10'h055};
        PcSrc = 1'b0; J_Jr = 1'b1;
        #1;
        tests++; if (wr_allow !== 1'b1) begin fails++; $display("FAIL jal_wr_allow: got %b expected 1", wr_allow); end
        tests++; if (opcode !== OP_JAL) begin fails++; $display("FAIL jal_opcode: got %0h expected %0h", opcode, OP_JAL); end
        tick(); nop();
        tests++; if (pc !== 10'h055) begin fails++; $display("FAIL jal: got %0h expected 55", pc); end
    endtask

    task automatic test_in_stall();
        goto(10'd8);
        imem_data = {OP_IN, 26'h0};
        Halt = 1'b1; in_valid = 1'b0; in_data = 32'hCAFE;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (wr_allow !== 1'b0) begin fails++; $display("FAIL in_wait_wr_allow_%0d: got %b expected 0", i, wr_allow); end
            tests++; if (in_ack !== 1'b0) begin fails++; $display("FAIL in_wait_ack_%0d: got %b expected 0", i, in_ack); end
            tick();
            tests++; if (pc !== 10'd8) begin fails++; $display("FAIL in_wait_pc_%0d: got %0h expected 8", i, pc); end
        end
        in_valid = 1'b1;
        #1;
        tests++; if (in_ack !== 1'b1) begin fails++; $display("FAIL in_ack_pulse: got %b expected 1", in_ack); end
        tests++; if (wr_allow !== 1'b1) begin fails++; $display("FAIL in_done_wr_allow: got %b expected 1", wr_allow); end
        tick(); nop();
        #1;
        tests++; if (in_ack !== 1'b0) begin fails++; $display("FAIL in_ack_single: got %b expected 0", in_ack); end
        tests++; if (in_value !== 32'hCAFE) begin fails++; $display("FAIL in_value: got %0h expected cafe", in_value); end
        tests++; if (pc !== 10'd9) begin fails++; $display("FAIL in_pc_next: got %0h expected 9", pc); end
        imem_data = {OP_IN, 26'h0};
        Halt = 1'b1; in_valid = 1'b1; in_data = 32'h1234;
        #1;
        tests++; if (in_ack !== 1'b1) begin fails++; $display("FAIL in_fast_ack: got %b expected 1", in_ack); end
        tick(); nop();
        tests++; if (pc !== 10'd10) begin fails++; $display("FAIL in_fast_pc: got %0h expected a", pc); end
        tests++; if (in_value !== 32'h1234) begin fails++; $display("FAIL in_fast_value: got %0h expected 1234", in_value); end
    endtask

    task automatic test_halt();
        goto(10'd12);
        imem_data = {OP_HALT, 26'h0};
        Halt = 1'b1;
        tick();
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag: got %b expected 1", halted); end
        imem_data = {OP_IN, 26'h0};
        in_valid = 1'b1; in_data = 32'h55;
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (pc !== 10'd12 || in_ack !== 1'b0 || wr_allow !== 1'b0) begin
                fails++;
                $display("FAIL halt_hold_%0d: got pc=%0h ack=%b wr=%b expected pc=c ack=0 wr=0", i, pc, in_ack, wr_allow);
            end
            tick();
        end
        rst_n = 1'b0;
        #2;
        tests++; if (pc !== 10'd0) begin fails++; $display("FAIL halt_reset_pc: got %0h expected 0", pc); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_reset_flag: got %b expected 0", halted); end
        nop();
        rst_n = 1'b1;
        imem_data = 32'h0;
        Halt = 1'b1;
        tick(); nop();
        tests++; if (halted !== 1'b1 || pc !== 10'd0) begin fails++; $display("FAIL halt_other_op: got halted=%b pc=%0h expected halted=1 pc=0", halted, pc); end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap_and_reset_wait();
        goto(10'd1023);
        tests++; if (pc !== 10'd1023) begin fails++; $display("FAIL goto_max: got %0h expected 3ff", pc); end
        tick();
        tests++; if (pc !== 10'd0) begin fails++; $display("FAIL seq_wrap: got %0h expected 0", pc); end
        goto(10'd20);
        imem_data = {OP_IN, 26'h0};
        Halt = 1'b1; in_valid = 1'b0;
        tick(); tick();
        tests++; if (pc !== 10'd20) begin fails++; $display("FAIL wait_pc: got %0h expected 14", pc); end
        in_valid = 1'b1; in_data = 32'hBEEF;
        rst_n = 1'b0;
        #1;
        tests++; if (in_ack !== 1'b0) begin fails++; $display("FAIL wait_reset_ack: got %b expected 0", in_ack); end
        tests++; if (pc !== 10'd0) begin fails++; $display("FAIL wait_reset_pc: got %0h expected 0", pc); end
        nop();
        rst_n = 1'b1;
        #1;
        tests++; if (wr_allow !== 1'b1) begin fails++; $display("FAIL wait_reset_run: got %b expected 1", wr_allow); end
        tick();
        tests++; if (pc !== 10'd1) begin fails++; $display("FAIL wait_reset_step: got %0h expected 1", pc); end
        tests++; if (in_value !== 32'h0) begin fails++; $display("FAIL wait_reset_value: got %0h expected 0", in_value); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_in_stall();
        test_halt();
        test_wrap_and_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
